if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//   Instruction-fetch stage: owns the PC, drives the synchronous instruction memory, and feeds
//   the IF/ID pipeline register. Its I_IFID_INSTRUCTION and I_IFID_PC are driven by this block.
//   Honours hazard stalls with a one-entry skid buffer.
//   Redirects on taken branch/jump and emits the IF/ID flush. Stops fetching on HALT.
// PARAMETERS
//   RESET_PC        32'h0000_0000  PC loaded on reset
//   IMEM_ADDR_W     10             instruction-memory word-address width
//   NOP_INSTR       32'hF800_0000  instruction value presented when output not valid
//   HALT_OPCODE     6'b111111      opcode [31:26] that halts fetch
// PORTS
//   CLK                 in   1   clock, rising edge
//   RESET               in   1   synchronous, active-high reset
//   I_IF_STALL          in   1   hazard stall: hold PC and presented instruction
//   I_IF_REDIRECT       in   1   taken branch/jump this cycle
//   I_IF_REDIRECT_PC    in   32  target byte address
//   O_IMEM_EN           out  1   memory read enable
//   O_IMEM_ADDR         out  IMEM_ADDR_W  word address
//   I_IMEM_DATA         in   32  read data, valid one cycle after O_IMEM_EN
//   O_IF_INSTRUCTION    out  32  instruction to IF/ID (NOP_INSTR when !O_IF_VALID)
//   O_IF_PC             out  32  PC+4 of presented instruction (0 when !O_IF_VALID)
//   O_IF_VALID          out  1   presented instruction is real
//   O_IF_FLUSH          out  1   flush IF/ID this cycle (drives its flush input)
//   O_IF_HALTED         out  1   fetch stopped on HALT
// BEHAVIOUR
//   - Regs: pc_q (next fetch), req_pc_q/req_valid_q (in-flight read), hold_instr/hold_pc/
//     hold_valid (skid), state in {RUN, HOLD, HALTED}.
//   - Reset: pc_q=RESET_PC, req_valid_q=0, hold_valid=0, state=RUN. During RESET:
//     O_IMEM_EN=0, O_IF_VALID=0, O_IF_FLUSH=0, O_IF_HALTED=0, O_IF_INSTRUCTION=NOP_INSTR, O_IF_PC=0.
//   - Addressing: O_IMEM_ADDR = fetch_pc[IMEM_ADDR_W+1:2]. Redirect target bits [1:0] are forced to 0.
//     PC arithmetic wraps modulo 2^32.
//   - Fetch latency: addr issued cycle t, instruction presented cycle t+1 from I_IMEM_DATA.
//   - Priority, highest first: RESET > I_IF_REDIRECT > I_IF_STALL > HALT detect > normal.
//   - RUN, no stall: O_IMEM_EN=1, addr=pc_q. Edge: req_pc_q<=pc_q, req_valid_q<=1, pc_q<=pc_q+4.
//   - RUN, stall: O_IMEM_EN=0, outputs still from memory this cycle.
//     Edge: hold_*<=presented instr/pc/valid, state->HOLD; pc_q and req_* unchanged.
//   - HOLD: outputs come from hold_*. O_IMEM_EN = !I_IF_STALL, addr=pc_q.
//     Stall still high: remain in HOLD.
//     Stall low: IF/ID takes the held instruction this cycle. Edge: req_pc_q<=pc_q, pc_q+=4,
//     hold_valid<=0, ->RUN.
//   - Redirect (any state, stall ignored): O_IF_FLUSH=1, O_IF_VALID=0, O_IMEM_EN=1,
//     addr=target. Edge: req_pc_q<=target, req_valid_q<=1, pc_q<=target+4, hold_valid<=0, ->RUN.
//   - HALT: valid presented opcode==HALT_OPCODE in RUN, no stall/redirect.
//     HALT itself is delivered. Edge: ->HALTED, pc_q frozen.
//   - HALTED: O_IMEM_EN=0, O_IF_VALID=0, O_IF_HALTED=1. Exit only by redirect (HALT in a
//     branch shadow) or RESET. Stall in HALTED has no effect.
//   - Reset mid-stall/mid-redirect: reset wins, and all skid/in-flight state is discarded.
// STRUCTURE
//   - Shared include mips_defs.vh: NOP_INSTR, HALT_OPCODE, PC width, fetch-state encodings
//     (also used by the IF/ID register and hazard unit).
//   - Sub-module if_skid_buffer: 1-entry capture/bypass mux (load, clear, data/pc/valid in/out).
//   - Top contains PC/FSM logic.
// TESTING
//   1 Reset then run: RESET 1 cycle -> addr 0,1,2 on consecutive cycles.
//     O_IF_PC 4,8,12 with O_IF_VALID=1 from cycle 2.
//   2 Stall 3 cycles while instr@PC 8 presented:
//     O_IF_INSTRUCTION/O_IF_PC (PC+4=12) constant for 4 cycles, O_IMEM_EN=0 during stall.
//     Next instruction then @12 with no gap and no duplicate.
//   3 Redirect to 32'h40 -> O_IF_FLUSH=1, O_IF_VALID=0 that cycle, addr=16.
//     Next cycle presents instr@0x40 with O_IF_PC=0x44.
//   4 Redirect and stall same cycle, including while in HOLD:
//     redirect wins, skid cleared, no stale instruction emitted.
//   5 HALT at PC 0x10: HALT presented once, then O_IF_HALTED=1 and O_IMEM_EN=0 indefinitely.
//     Redirect to 0x80 resumes at 0x80.
//   6 RESET asserted during HOLD and during HALTED -> all outputs at reset values next cycle.
//     Fetch restarts at RESET_PC. Plus PC wrap at 32'hFFFF_FFFC -> next PC 0.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage constants and state encoding, also used by the IF/ID register and hazard unit.
package if_fetch_unit_pkg;

  localparam int unsigned PcW        = 32;
  localparam logic [31:0] NopInstr   = 32'hF800_0000;
  localparam logic [5:0]  HaltOpcode = 6'b111111;

  typedef enum logic [1:0] {
    StRun,
    StHold,
    StHalted
  } fetch_state_e;

  function automatic logic [PcW-1:0] word_align(input logic [PcW-1:0] pc);
    return {pc[PcW-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bundle: hazard/branch inputs, instruction-memory port and IF/ID outputs.
interface if_fetch_unit_if
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned ImemAddrW = 10
);
  logic                 stall;
  logic                 redirect;
  logic [PcW-1:0]       redirect_pc;
  logic                 imem_en;
  logic [ImemAddrW-1:0] imem_addr;
  logic [31:0]          imem_data;
  logic [31:0]          if_instruction;
  logic [PcW-1:0]       if_pc;
  logic                 if_valid;
  logic                 if_flush;
  logic                 if_halted;

  modport master (
    input  stall, redirect, redirect_pc, imem_data,
    output imem_en, imem_addr, if_instruction, if_pc, if_valid, if_flush, if_halted
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_data,
    input  imem_en, imem_addr, if_instruction, if_pc, if_valid, if_flush, if_halted
  );
endinterface

// File: rtl/if_fetch_unit_skid_buffer.sv
// One-entry skid: captures the presented instruction on load and muxes it back out while held.
module if_skid_buffer
  import if_fetch_unit_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           load_i,
  input  logic           clear_i,
  input  logic           use_hold_i,
  input  logic [31:0]    instr_i,
  input  logic [PcW-1:0] pc_i,
  input  logic           valid_i,
  output logic [31:0]    instr_o,
  output logic [PcW-1:0] pc_o,
  output logic           valid_o
);

  logic [31:0]    hold_instr_q;
  logic [PcW-1:0] hold_pc_q;
  logic           hold_valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_instr_q <= NopInstr;
      hold_pc_q    <= '0;
      hold_valid_q <= 1'b0;
    end else if (clear_i) begin
      hold_valid_q <= 1'b0;
    end else if (load_i) begin
      hold_instr_q <= instr_i;
      hold_pc_q    <= pc_i;
      hold_valid_q <= valid_i;
    end
  end

  always_comb begin
    instr_o = instr_i;
    pc_o    = pc_i;
    valid_o = valid_i;
    if (use_hold_i) begin
      instr_o = hold_instr_q;
      pc_o    = hold_pc_q;
      valid_o = hold_valid_q;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC and fetch FSM, synchronous imem driver, stall skid, redirect and HALT.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] ResetPc     = 32'h0000_0000,
  parameter int unsigned ImemAddrW   = 10,
  parameter logic [31:0] NopInstrP   = NopInstr,
  parameter logic [5:0]  HaltOpcodeP = HaltOpcode
) (
  input  logic              clk_i,
  input  logic              rst_i,
  if_fetch_unit_if.master   fetch_io
);

  fetch_state_e   state_q, state_d;
  logic [PcW-1:0] pc_q, pc_d;
  logic [PcW-1:0] req_pc_q, req_pc_d;
  logic           req_valid_q, req_valid_d;

  logic [PcW-1:0] fetch_pc, target;
  logic           skid_load, skid_clear;
  logic [31:0]    pres_instr;
  logic [PcW-1:0] pres_pc;
  logic           pres_valid, is_halt, out_valid;

  if_skid_buffer u_skid (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (skid_load),
    .clear_i    (skid_clear),
    .use_hold_i (state_q == StHold),
    .instr_i    (fetch_io.imem_data),
    .pc_i       (req_pc_q + 32'd4),
    .valid_i    (req_valid_q),
    .instr_o    (pres_instr),
    .pc_o       (pres_pc),
    .valid_o    (pres_valid)
  );

  assign target  = word_align(fetch_io.redirect_pc);
  assign is_halt = pres_valid && (pres_instr[31:26] == HaltOpcodeP);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    req_valid_d = req_valid_q;
    skid_load   = 1'b0;
    skid_clear  = 1'b0;
    fetch_pc    = pc_q;
    out_valid   = pres_valid;
    fetch_io.imem_en   = 1'b0;
    fetch_io.if_flush  = 1'b0;
    fetch_io.if_halted = 1'b0;

    if (rst_i) begin
      fetch_pc  = ResetPc;
      out_valid = 1'b0;
    end else if (fetch_io.redirect) begin
      fetch_io.if_flush = 1'b1;
      fetch_io.imem_en  = 1'b1;
      out_valid   = 1'b0;
      fetch_pc    = target;
      req_pc_d    = target;
      req_valid_d = 1'b1;
      pc_d        = target + 32'd4;
      skid_clear  = 1'b1;
      state_d     = StRun;
    end else begin
      unique case (state_q)
        StRun: begin
          if (fetch_io.stall) begin
            skid_load = 1'b1;
            state_d   = StHold;
          end else if (is_halt) begin
            req_valid_d = 1'b0;
            state_d     = StHalted;
          end else begin
            fetch_io.imem_en = 1'b1;
            req_pc_d    = pc_q;
            req_valid_d = 1'b1;
            pc_d        = pc_q + 32'd4;
          end
        end
        StHold: begin
          // Releasing the stall hands the held word to IF/ID; a held HALT still stops fetch.
          if (!fetch_io.stall) begin
            skid_clear = 1'b1;
            if (is_halt) begin
              req_valid_d = 1'b0;
              state_d     = StHalted;
            end else begin
              fetch_io.imem_en = 1'b1;
              req_pc_d    = pc_q;
              req_valid_d = 1'b1;
              pc_d        = pc_q + 32'd4;
              state_d     = StRun;
            end
          end
        end
        StHalted: begin
          out_valid          = 1'b0;
          fetch_io.if_halted = 1'b1;
        end
        default: state_d = StRun;
      endcase
    end

    fetch_io.if_valid       = out_valid;
    fetch_io.if_instruction = out_valid ? pres_instr : NopInstrP;
    fetch_io.if_pc          = out_valid ? pres_pc : '0;
    fetch_io.imem_addr      = fetch_pc[ImemAddrW+1:2];
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[PcW-1:ImemAddrW+2], fetch_pc[1:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StRun;
      pc_q        <= ResetPc;
      req_pc_q    <= ResetPc;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed vector bench for if_fetch_unit with a synchronous instruction-memory model.
module tb_if_fetch_unit;

  localparam logic [31:0] Nop  = 32'hF800_0000;
  localparam logic [31:0] Halt = 32'hFC00_0000;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] tgt;
    logic        en;
    logic [9:0]  addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        flush;
    logic        halted;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] mem [1024];
  int vectors = 0;
  int miscompares = 0;

  if_fetch_unit_if #(.ImemAddrW(10)) fi ();

  if_fetch_unit #(.ResetPc(32'h0), .ImemAddrW(10)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .fetch_io (fi)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fi.imem_en) fi.imem_data <= mem[fi.imem_addr];
  end

  // Expected word at byte address p (HALT lives at 0x10 only).
  function automatic logic [31:0] iw(input logic [31:0] p);
    logic [31:0] w;
    w = (p >> 2) & 32'h3FF;
    return (w == 32'd4) ? Halt : (32'h1000_0000 + w);
  endfunction

  function automatic vec_t mk(input logic r, s, d, input logic [31:0] t, input logic en,
                              input int addr, input logic [31:0] ins, pc,
                              input logic val, fl, ha);
    vec_t v;
    v.rst = r; v.stall = s; v.redir = d; v.tgt = t;
    v.en = en; v.addr = addr[9:0]; v.instr = ins; v.pc = pc;
    v.valid = val; v.flush = fl; v.halted = ha;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, exp);
    if (act !== exp) begin
      $display("FAIL %s @vec %0d: got %h want %h", name, idx, act, exp);
      miscompares++;
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst = v.rst;
    fi.stall = v.stall;
    fi.redirect = v.redir;
    fi.redirect_pc = v.tgt;
    #1;
    vectors++;
    chk("imem_en", idx, {31'b0, fi.imem_en}, {31'b0, v.en});
    if (v.en) chk("imem_addr", idx, {22'b0, fi.imem_addr}, {22'b0, v.addr});
    chk("instr", idx, fi.if_instruction, v.instr);
    chk("pc", idx, fi.if_pc, v.pc);
    chk("valid", idx, {31'b0, fi.if_valid}, {31'b0, v.valid});
    chk("flush", idx, {31'b0, fi.if_flush}, {31'b0, v.flush});
    chk("halted", idx, {31'b0, fi.if_halted}, {31'b0, v.halted});
  endtask

  vec_t vq[$];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
    mem[4] = Halt;
    fi.stall = 1'b0;
    fi.redirect = 1'b0;
    fi.redirect_pc = 32'h0;
    fi.imem_data = 32'h0;

    //         rst s  d  target          en addr ins                pc          v  fl ha
    vq.push_back(mk(1, 0, 0, 32'h0,        0, 0,    Nop,               32'h0,      0, 0, 0));
    vq.push_back(mk(0, 0, 0, 32'h0,        1, 0,    Nop,               32'h0,      0, 0, 0));
    vq.push_back(mk(0, 0, 0, 32'h0,        1, 1,    iw(32'h0),         32'h4,      1, 0, 0));
    vq.push_back(mk(0, 0, 0, 32'h0,        1, 2,    iw(32'h4),         32'h8,      1, 0, 0));
    // Stall three cycles over the word at 8.
    vq.push_back(mk(0, 1, 0, 32'h0,        0, 3,    iw(32'h8),         32'hC,      1, 0, 0));
    vq.push_back(mk(0, 1, 0, 32'h0,        0, 3,    iw(32'h8),         32'hC,      1, 0, 0));
    vq.push_back(mk(0, 1, 0, 32'h0,        0, 3,    iw(32'h8),         32'hC,      1, 0, 0));
    vq.push_back(mk(0, 0, 0, 32'h0,        1, 3,    iw(32'h8),         32'hC,      1, 0, 0));
    vq.push_back(mk(0, 0, 0, 32'h0,        1, 4,    iw(32'hC),         32'h10,     1, 0, 0));
    // Redirect to 0x40 while the HALT word at 0x10 is arriving: it must be squashed.
    vq.push_back(mk(0, 0, 1, 32'h40,       1, 16,   Nop,               32'h0,      0, 1, 0));
    vq.push_back(mk(0, 0, 0, 32'h0,        1, 17,   iw(32'h40),        32'h44,     1, 0, 0));
    // Redirect + stall in RUN, then in HOLD (target with low bits set).
    vq.push_back(mk(0, 1, 1, 32'h100,      1, 64,   Nop,               32'h0,      0, 1, 0));
    vq.push_back(mk(0, 0, 0, 32'h0,        1, 65,   iw(32'h100),       32'h104,    1, 0, 0));
    vq.push_back(mk(0, 1, 0, 32'h0,        0, 66,   iw(32'h104),       32'h108,    1, 0, 0));
    vq.push_back(mk(0, 1, 1, 32'h202,      1, 128,  Nop,               32'h0,      0, 1, 0));
    vq.push_back(mk(0, 1, 0, 32'h0,        0, 129,  iw(32'h200),       32'h204,    1, 0, 0));
    vq.push_back(mk(0, 0, 0, 32'h0,        1, 129,  iw(32'h200),       32'h204,    1, 0, 0));
    vq.push_back(mk(0, 0, 0, 32'h0,        1, 130,  iw(32'h204),       32'h208,    1, 0, 0));
    // HALT at 0x10, stall ignored while halted, resume at 0x80.
    vq.push_back(mk(0, 0, 1, 32'h10,       1, 4,    Nop,               32'h0,      0, 1, 0));
    vq.push_back(mk(0, 0, 0, 32'h0,        0, 5,    Halt,              32'h14,     1, 0, 0));
    vq.push_back(mk(0, 0, 0, 32'h0,        0, 5,    Nop,               32'h0,      0, 0, 1));
    vq.push_back(mk(0, 1, 0, 32'h0,        0, 5,    Nop,               32'h0,      0, 0, 1));
    vq.push_back(mk(0, 0, 1, 32'h80,       1, 32,   Nop,               32'h0,      0, 1, 0));
    vq.push_back(mk(0, 0, 0, 32'h0,        1, 33,   iw(32'h80),        32'h84,     1, 0, 0));
    // Reset during HOLD.
    vq.push_back(mk(0, 1, 0, 32'h0,        0, 34,   iw(32'h84),        32'h88,     1, 0, 0));
    vq.push_back(mk(0, 1, 0, 32'h0,        0, 34,   iw(32'h84),        32'h88,     1, 0, 0));
    vq.push_back(mk(1, 1, 0, 32'h0,        0, 0,    Nop,               32'h0,      0, 0, 0));
    vq.push_back(mk(0, 0, 0, 32'h0,        1, 0,    Nop,               32'h0,      0, 0, 0));
    vq.push_back(mk(0, 0, 0, 32'h0,        1, 1,    iw(32'h0),         32'h4,      1, 0, 0));
    // Reset during HALTED.
    vq.push_back(mk(0, 0, 1, 32'h10,       1, 4,    Nop,               32'h0,      0, 1, 0));
    vq.push_back(mk(0, 0, 0, 32'h0,        0, 5,    Halt,              32'h14,     1, 0, 0));
    vq.push_back(mk(0, 0, 0, 32'h0,        0, 5,    Nop,               32'h0,      0, 0, 1));
    vq.push_back(mk(1, 0, 0, 32'h0,        0, 0,    Nop,               32'h0,      0, 0, 0));
    vq.push_back(mk(0, 0, 0, 32'h0,        1, 0,    Nop,               32'h0,      0, 0, 0));
    vq.push_back(mk(0, 0, 0, 32'h0,        1, 1,    iw(32'h0),         32'h4,      1, 0, 0));
    // PC wrap at the top of the address space.
    vq.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 1, 1023, Nop,              32'h0,      0, 1, 0));
    vq.push_back(mk(0, 0, 0, 32'h0,        1, 0,    iw(32'hFFFF_FFFC), 32'h0,      1, 0, 0));
    vq.push_back(mk(0, 0, 0, 32'h0,        1, 1,    iw(32'h0),         32'h4,      1, 0, 0));

    foreach (vq[i]) apply(vq[i], i);

    // Long HALTED dwell with random stall, then resume through a redirect.
    apply(mk(0, 0, 1, 32'h10, 1, 4, Nop, 32'h0, 0, 1, 0), 100);
    apply(mk(0, 0, 0, 32'h0, 0, 5, Halt, 32'h14, 1, 0, 0), 101);
    for (int k = 0; k < 12; k++) begin
      apply(mk(0, 1'($urandom_range(0, 1)), 0, 32'h0, 0, 5, Nop, 32'h0, 0, 0, 1), 102 + k);
    end
    apply(mk(0, 0, 1, 32'h80, 1, 32, Nop, 32'h0, 0, 1, 0), 120);
    apply(mk(0, 0, 0, 32'h0, 1, 33, iw(32'h80), 32'h84, 1, 0, 0), 121);
    apply(mk(0, 0, 0, 32'h0, 1, 34, iw(32'h84), 32'h88, 1, 0, 0), 122);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
